// File: rtl/msrv32_pc_gen.sv
// msrv32 fetch-stage program-counter generator.
// Holds the fetch PC and issues a valid/ready request to instruction memory.
// The next PC comes from boot, EPC, trap, branch/jump or sequential sources.
// A redirect that arrives while a request is stalled is parked in pend_pc
// until that request completes. The completing request is then flagged as
// stale through fetch_discard_out.
module msrv32_pc_gen #(
   parameter int unsigned       XLEN         = 32,
   parameter logic [XLEN-1:0]   BOOT_ADDRESS = '0,
   // 32, or 16 to enable compressed (16-bit aligned) instructions
   parameter int unsigned       IALIGN       = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            redirect_valid_in,
   input  logic [1:0]      pc_src_in,
   input  logic            branch_taken_in,
   input  logic [XLEN-2:0] iaddr_in,
   input  logic [XLEN-1:0] epc_in,
   input  logic [XLEN-1:0] trap_address_in,
   input  logic            compressed_in,
   input  logic            fetch_ready_in,
   output logic            fetch_valid_out,
   output logic [XLEN-1:0] i_addr_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus_inc_out,
   output logic            misaligned_instr_out,
   output logic            fetch_discard_out
);

   // Any IALIGN other than 16 behaves as 32-bit alignment.
   localparam bit CompressedEn = (IALIGN == 16);

   localparam logic [1:0] SrcBoot = 2'b00;
   localparam logic [1:0] SrcEpc  = 2'b01;
   localparam logic [1:0] SrcTrap = 2'b10;
   localparam logic [1:0] SrcNext = 2'b11;

   typedef enum logic [1:0] {
      StBoot = 2'b00,
      StRun  = 2'b01,
      StPend = 2'b10
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            valid_q, valid_d;

   logic [XLEN-1:0] inc;
   logic [XLEN-1:0] pc_plus_inc;
   logic [XLEN-1:0] target;
   logic            misaligned;
   logic            redirect_ok;
   logic            fire;

   // Increment, candidate target and misalignment decode.
   always_comb begin
      inc         = (CompressedEn && compressed_in) ? XLEN'(2) : XLEN'(4);
      pc_plus_inc = pc_q + inc;

      target = pc_plus_inc;
      unique case (pc_src_in)
         SrcBoot: target = BOOT_ADDRESS;
         SrcEpc:  target = epc_in;
         SrcTrap: target = trap_address_in;
         SrcNext: target = branch_taken_in ? {iaddr_in, 1'b0} : pc_plus_inc;
         default: target = pc_plus_inc;
      endcase

      // Only taken branches can be misaligned, and only under 32-bit alignment.
      misaligned = 1'b0;
      if (!CompressedEn) begin
         misaligned = redirect_valid_in && (pc_src_in == SrcNext) && branch_taken_in
                      && target[1];
      end

      // A misaligned redirect is dropped. The trap unit redirects later.
      redirect_ok = redirect_valid_in && !misaligned;
      fire        = valid_q && fetch_ready_in;
   end

   // Next-state logic for the fetch FSM, PC and parked redirect.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;

      unique case (state_q)
         // Redirects in BOOT are ignored. Fetching starts at BOOT_ADDRESS.
         StBoot: state_d = StRun;

         StRun: begin
            if (redirect_ok) begin
               if (fire) begin
                  pc_d = target;
               end else begin
                  // Keep the stalled request stable and park the redirect.
                  pend_pc_d = target;
                  state_d   = StPend;
               end
            end else if (fire) begin
               pc_d = pc_plus_inc;
            end
         end

         StPend: begin
            if (fire) begin
               // A same-cycle redirect is newer than the parked one.
               pc_d    = redirect_ok ? target : pend_pc_q;
               state_d = StRun;
            end else if (redirect_ok) begin
               pend_pc_d = target;
            end
         end

         default: state_d = StBoot;
      endcase

      // The request is valid in every state except BOOT.
      valid_d = (state_d != StBoot);
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= StBoot;
         pc_q      <= BOOT_ADDRESS;
         pend_pc_q <= BOOT_ADDRESS;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         valid_q   <= valid_d;
      end
   end

   // Output drive. fetch_discard_out marks completion of a superseded request.
   always_comb begin
      fetch_valid_out      = valid_q;
      i_addr_out           = pc_q;
      pc_out               = pc_q;
      pc_plus_inc_out      = pc_plus_inc;
      misaligned_instr_out = misaligned;
      fetch_discard_out    = (state_q == StPend) && fire;
   end

`ifndef SYNTHESIS
   // A stalled request must not change its address.
   a_req_stable : assert property (@(posedge clk_in) disable iff (rst_in)
      (fetch_valid_out && !fetch_ready_in) |=> $stable(i_addr_out));

   // A discard can only accompany a completing request.
   a_discard_fire : assert property (@(posedge clk_in) disable iff (rst_in)
      fetch_discard_out |-> (fetch_valid_out && fetch_ready_in));
`endif

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Self-checking bench for msrv32_pc_gen.
// Two instances share one input stream:
//   - k=0: IALIGN=32 with BOOT_ADDRESS=0x100
//   - k=1: IALIGN=16 with BOOT_ADDRESS=0x200
// A directed table covers the key scenarios, and a random phase follows.
// Both phases are also checked against a behavioural model.
module tb_msrv32_pc_gen;

   typedef struct {
      logic        rst;
      logic        rv;
      logic [1:0]  src;
      logic        bt;
      logic [30:0] iaddr;
      logic [31:0] epc;
      logic [31:0] trap;
      logic        comp;
      logic        ready;
   } in_t;

   typedef struct {
      in_t         in;
      logic        e_valid;
      logic [31:0] e_a32;
      logic [31:0] e_ppi32;
      logic        e_disc;
      logic        e_mis32;
      logic [31:0] e_a16;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv;
   logic [1:0]  src;
   logic        bt;
   logic [30:0] iaddr;
   logic [31:0] epc;
   logic [31:0] trap;
   logic        comp;
   logic        ready;

   logic        valid32, mis32, disc32;
   logic [31:0] addr32, pc32, ppi32;
   logic        valid16, mis16, disc16;
   logic [31:0] addr16, pc16, ppi16;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state, one slot per instance.
   logic        m_boot    [2];
   logic        m_pend    [2];
   logic [31:0] m_pc      [2];
   logic [31:0] m_pend_pc [2];

   always #5 clk = ~clk;

   msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h100), .IALIGN(32)) dut32 (
      .clk_in(clk), .rst_in(rst), .redirect_valid_in(rv), .pc_src_in(src),
      .branch_taken_in(bt), .iaddr_in(iaddr), .epc_in(epc), .trap_address_in(trap),
      .compressed_in(comp), .fetch_ready_in(ready), .fetch_valid_out(valid32),
      .i_addr_out(addr32), .pc_out(pc32), .pc_plus_inc_out(ppi32),
      .misaligned_instr_out(mis32), .fetch_discard_out(disc32)
   );

   msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h200), .IALIGN(16)) dut16 (
      .clk_in(clk), .rst_in(rst), .redirect_valid_in(rv), .pc_src_in(src),
      .branch_taken_in(bt), .iaddr_in(iaddr), .epc_in(epc), .trap_address_in(trap),
      .compressed_in(comp), .fetch_ready_in(ready), .fetch_valid_out(valid16),
      .i_addr_out(addr16), .pc_out(pc16), .pc_plus_inc_out(ppi16),
      .misaligned_instr_out(mis16), .fetch_discard_out(disc16)
   );

   function automatic logic [31:0] boot_of(input int k);
      return (k == 0) ? 32'h100 : 32'h200;
   endfunction

   function automatic logic [31:0] inc_of(input int k, input in_t i);
      return (k == 1 && i.comp) ? 32'd2 : 32'd4;
   endfunction

   function automatic logic [31:0] target_of(input int k, input in_t i);
      case (i.src)
         2'd0:    return boot_of(k);
         2'd1:    return i.epc;
         2'd2:    return i.trap;
         default: return i.bt ? {i.iaddr, 1'b0} : m_pc[k] + inc_of(k, i);
      endcase
   endfunction

   function automatic logic mis_of(input int k, input in_t i);
      logic [31:0] t;
      t = target_of(k, i);
      return (k == 0) && i.rv && (i.src == 2'd3) && i.bt && t[1];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_boot[k]    = 1'b1;
         m_pend[k]    = 1'b0;
         m_pc[k]      = boot_of(k);
         m_pend_pc[k] = boot_of(k);
      end
   endtask

   // One rising edge of the model.
   task automatic model_advance(input in_t i);
      for (int k = 0; k < 2; k++) begin
         logic        fire, redir;
         logic [31:0] t;
         fire  = !m_boot[k] && i.ready;
         redir = i.rv && !mis_of(k, i);
         t     = target_of(k, i);
         if (m_boot[k]) begin
            m_boot[k] = 1'b0;
         end else if (m_pend[k]) begin
            if (fire) begin
               m_pc[k]   = redir ? t : m_pend_pc[k];
               m_pend[k] = 1'b0;
            end else if (redir) begin
               m_pend_pc[k] = t;
            end
         end else if (redir) begin
            if (fire) begin
               m_pc[k] = t;
            end else begin
               m_pend[k]    = 1'b1;
               m_pend_pc[k] = t;
            end
         end else if (fire) begin
            m_pc[k] = m_pc[k] + inc_of(k, i);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_model(input in_t i);
      chk("m32_valid", {31'd0, valid32}, {31'd0, !m_boot[0]});
      chk("m32_addr",  addr32, m_pc[0]);
      chk("m32_pc",    pc32,   m_pc[0]);
      chk("m32_ppi",   ppi32,  m_pc[0] + inc_of(0, i));
      chk("m32_mis",   {31'd0, mis32}, {31'd0, mis_of(0, i)});
      chk("m32_disc",  {31'd0, disc32}, {31'd0, m_pend[0] && !m_boot[0] && i.ready});
      chk("m16_valid", {31'd0, valid16}, {31'd0, !m_boot[1]});
      chk("m16_addr",  addr16, m_pc[1]);
      chk("m16_pc",    pc16,   m_pc[1]);
      chk("m16_ppi",   ppi16,  m_pc[1] + inc_of(1, i));
      chk("m16_mis",   {31'd0, mis16}, 32'd0);
      chk("m16_disc",  {31'd0, disc16}, {31'd0, m_pend[1] && !m_boot[1] && i.ready});
   endtask

   task automatic drive(input in_t i);
      rst   = i.rst;
      rv    = i.rv;
      src   = i.src;
      bt    = i.bt;
      iaddr = i.iaddr;
      epc   = i.epc;
      trap  = i.trap;
      comp  = i.comp;
      ready = i.ready;
      if (i.rst) model_reset();
   endtask

   // Drive one cycle, sample mid-cycle, then let the edge happen.
   task automatic finish_cycle(input in_t i);
      @(posedge clk);
      if (!i.rst) model_advance(i);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                               input logic b, input logic [30:0] ia, input logic [31:0] ep,
                               input logic [31:0] tr, input logic c, input logic rd,
                               input logic ev, input logic [31:0] a32, input logic ed,
                               input logic em, input logic [31:0] a16);
      vec_t x;
      x.in.rst   = r;
      x.in.rv    = v;
      x.in.src   = s;
      x.in.bt    = b;
      x.in.iaddr = ia;
      x.in.epc   = ep;
      x.in.trap  = tr;
      x.in.comp  = c;
      x.in.ready = rd;
      x.e_valid  = ev;
      x.e_a32    = a32;
      x.e_ppi32  = a32 + 32'd4;
      x.e_disc   = ed;
      x.e_mis32  = em;
      x.e_a16    = a16;
      return x;
   endfunction

   vec_t vecs [22];
   in_t  ri;

   initial begin
      // Fields: rst rv src bt iaddr epc trap comp ready, then valid a32 disc mis a16.
      vecs[0]  = mk(1, 0, 0, 0, 0,     0,     0,            0, 0, 0, 32'h100, 0, 0, 32'h200);
      vecs[1]  = mk(0, 0, 0, 0, 0,     0,     0,            0, 1, 0, 32'h100, 0, 0, 32'h200);
      vecs[2]  = mk(0, 0, 0, 0, 0,     0,     0,            1, 1, 1, 32'h100, 0, 0, 32'h200);
      vecs[3]  = mk(0, 0, 0, 0, 0,     0,     0,            0, 1, 1, 32'h104, 0, 0, 32'h202);
      vecs[4]  = mk(0, 0, 0, 0, 0,     0,     0,            1, 1, 1, 32'h108, 0, 0, 32'h206);
      vecs[5]  = mk(0, 0, 0, 0, 0,     0,     0,            0, 0, 1, 32'h10C, 0, 0, 32'h208);
      vecs[6]  = mk(0, 1, 2, 0, 0,     0,     32'h40,       0, 1, 1, 32'h10C, 0, 0, 32'h208);
      vecs[7]  = mk(0, 1, 2, 0, 0,     0,     32'h80,       0, 0, 1, 32'h40,  0, 0, 32'h40);
      vecs[8]  = mk(0, 1, 1, 0, 0,     32'h90, 0,           0, 0, 1, 32'h40,  0, 0, 32'h40);
      vecs[9]  = mk(0, 0, 0, 0, 0,     0,     0,            0, 0, 1, 32'h40,  0, 0, 32'h40);
      vecs[10] = mk(0, 0, 0, 0, 0,     0,     0,            0, 1, 1, 32'h40,  1, 0, 32'h40);
      vecs[11] = mk(0, 0, 0, 0, 0,     0,     0,            0, 1, 1, 32'h90,  0, 0, 32'h90);
      vecs[12] = mk(0, 1, 3, 1, 'h801, 0,     0,            0, 1, 1, 32'h94,  0, 1, 32'h94);
      vecs[13] = mk(0, 0, 0, 0, 0,     0,     0,            0, 1, 1, 32'h98,  0, 0, 32'h1002);
      vecs[14] = mk(0, 1, 2, 0, 0,     0,     32'hFFFFFFFC, 0, 1, 1, 32'h9C,  0, 0, 32'h1006);
      vecs[15] = mk(0, 0, 0, 0, 0,     0,     0,            0, 1, 1, 32'hFFFFFFFC, 0, 0,
                    32'hFFFFFFFC);
      vecs[16] = mk(0, 0, 0, 0, 0,     0,     0,            0, 0, 1, 32'h0,   0, 0, 32'h0);
      vecs[17] = mk(0, 1, 2, 0, 0,     0,     32'h300,      0, 0, 1, 32'h0,   0, 0, 32'h0);
      vecs[18] = mk(1, 0, 0, 0, 0,     0,     0,            0, 0, 0, 32'h100, 0, 0, 32'h200);
      vecs[19] = mk(0, 0, 0, 0, 0,     0,     0,            0, 1, 0, 32'h100, 0, 0, 32'h200);
      vecs[20] = mk(0, 0, 0, 0, 0,     0,     0,            0, 1, 1, 32'h100, 0, 0, 32'h200);
      vecs[21] = mk(0, 0, 0, 0, 0,     0,     0,            0, 0, 1, 32'h104, 0, 0, 32'h204);

      rst = 1'b0; rv = 1'b0; src = 2'd0; bt = 1'b0; iaddr = '0;
      epc = '0; trap = '0; comp = 1'b0; ready = 1'b0;
      model_reset();
      #1;

      // Directed table: hand-derived expectations plus model cross-check.
      for (int n = 0; n < 22; n++) begin
         drive(vecs[n].in);
         #2;
         chk($sformatf("v%0d_valid32", n), {31'd0, valid32}, {31'd0, vecs[n].e_valid});
         chk($sformatf("v%0d_valid16", n), {31'd0, valid16}, {31'd0, vecs[n].e_valid});
         chk($sformatf("v%0d_addr32", n), addr32, vecs[n].e_a32);
         chk($sformatf("v%0d_ppi32", n), ppi32, vecs[n].e_ppi32);
         chk($sformatf("v%0d_disc32", n), {31'd0, disc32}, {31'd0, vecs[n].e_disc});
         chk($sformatf("v%0d_disc16", n), {31'd0, disc16}, {31'd0, vecs[n].e_disc});
         chk($sformatf("v%0d_mis32", n), {31'd0, mis32}, {31'd0, vecs[n].e_mis32});
         chk($sformatf("v%0d_addr16", n), addr16, vecs[n].e_a16);
         check_model(vecs[n].in);
         finish_cycle(vecs[n].in);
      end

      // Randomized stimulus against the model.
      for (int n = 0; n < 3000; n++) begin
         ri.rst   = ($urandom_range(0, 199) == 0);
         ri.rv    = ($urandom_range(0, 2) == 0);
         ri.src   = 2'($urandom_range(0, 3));
         ri.bt    = 1'($urandom_range(0, 1));
         ri.iaddr = 31'($urandom);
         ri.epc   = $urandom;
         ri.trap  = $urandom & 32'hFFFF_FFFC;
         ri.comp  = 1'($urandom_range(0, 1));
         ri.ready = ($urandom_range(0, 3) != 0);
         drive(ri);
         #2;
         check_model(ri);
         finish_cycle(ri);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
